jk_cmd_sequencer: RTL
=====================

JK_CMD_SEQUENCER -- requirements
Module: jk_cmd_sequencer

Interface
REQ-001 Parameter DEPTH, default 4, command FIFO entries (power of two, >=2) SHALL be supported.
REQ-002 Parameter LEN_W, default 4, repeat-count field width SHALL be supported.
REQ-003 clk  input  1  sole clock; all state SHALL update on posedge clk.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 cmd_valid  input  1  command offered.
REQ-006 cmd_ready  output  1  FIFO can accept; SHALL equal !full.
REQ-007 cmd_op  input  2  {j,k} to drive: 00 hold, 01 reset, 10 set, 11 toggle.
REQ-008 cmd_len  input  LEN_W  cycles to hold the op; 0 encodes 2^LEN_W.
REQ-009 j  output  1  registered J drive to downstream JK flip-flop.
REQ-010 k  output  1  registered K drive to downstream JK flip-flop.
REQ-011 busy  output  1  high while in DRIVE or FIFO non-empty.
REQ-012 done  output  1  one-cycle pulse during the last drive cycle of each command.
REQ-013 q_shadow  output  1  predicted downstream q (see Configuration).

Function
REQ-014 Accept on posedge with cmd_valid && cmd_ready; {cmd_op,cmd_len} SHALL be written to the FIFO tail.
REQ-015 cmd_valid while full SHALL be ignored; no overwrite, no count change.
REQ-016 Simultaneous push and pop when not full SHALL leave occupancy unchanged; no bypass when full.
REQ-017 FSM states: IDLE, DRIVE.
REQ-018 IDLE: j=k=0; if FIFO non-empty, next edge pops head, loads j,k=op, loads cycle counter=len, enters DRIVE.
REQ-019 Latency: command pushed into an empty FIFO at edge N SHALL appear on j/k after edge N+1.
REQ-020 DRIVE: j/k SHALL stay constant for exactly len cycles (2^LEN_W if len=0); counter decrements each edge.
REQ-021 Last cycle (counter==1): done=1; if FIFO non-empty, next command SHALL load at that edge with no bubble; else return to IDLE with j=k=0.
REQ-022 Back-to-back commands with equal op SHALL still pulse done once per command.
REQ-023 FIFO pointers SHALL wrap modulo DEPTH; occupancy counter width clog2(DEPTH)+1.
REQ-024 busy SHALL be 0 only when IDLE and FIFO empty.

Reset
REQ-025 rst high at a posedge SHALL clear FIFO (occupancy 0), state IDLE, counter 0, j=0, k=0, done=0, q_shadow=0, cmd_ready=1 after that edge.
REQ-026 rst mid-DRIVE SHALL abort the active command without done and discard queued commands; a push coinciding with rst SHALL be dropped.

Configuration
REQ-027 Macro JK_CMD_SEQUENCER_SHADOW_EN: defined -> q_shadow updates every posedge from current registered j,k per JK rule (00 hold, 01 ->0, 10 ->1, 11 invert).
REQ-028 Undefined -> q_shadow SHALL be constant 0 and no shadow register synthesized; port remains.

Verification
REQ-029 Reset, then push op=10 len=3 into empty FIFO at edge N -> j=1,k=0 for edges N+1..N+3 outputs, done high in third cycle, then j=k=0, busy=0.
REQ-030 Push ops 10/len1, 11/len2, 01/len1 back-to-back -> j/k sequence 10,11,11,01 with no idle gap, done pulses 3, q_shadow (SHADOW_EN) 1,0,1,0.
REQ-031 Hold cmd_valid with len=0 ops until full (DEPTH=4) -> cmd_ready=0 after 4 accepts plus one popped, extra offers ignored, all accepted commands drive 16 cycles each in order.
REQ-032 Assert rst during second cycle of a len=5 command with 2 queued -> next cycle j=k=0, busy=0, no done, cmd_ready=1, queued commands never appear.
REQ-033 Push during last cycle of active command with FIFO empty -> command starts one edge after IDLE entry per REQ-019, one cycle of j=k=0 between.
REQ-034 Build without JK_CMD_SEQUENCER_SHADOW_EN, run REQ-030 -> j/k identical, q_shadow 0 throughout.

Source files
------------

// File: rtl/jk_cmd_sequencer.sv
// Command FIFO feeding a JK flip-flop driver: each command holds {j,k} for a
// programmable number of cycles. Optional q prediction via JK_CMD_SEQUENCER_SHADOW_EN.
module jk_cmd_sequencer #(
  parameter int DEPTH = 4,
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [LEN_W-1:0] cmd_len,
  output logic             j,
  output logic             k,
  output logic             busy,
  output logic             done,
  output logic             q_shadow
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int NW = LEN_W + 1;
  localparam int EW = LEN_W + 2;

  typedef enum logic {IDLE, DRIVE} state_t;

  logic [EW-1:0]    mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic [NW-1:0]    cnt;
  state_t           state;

  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic [EW-1:0]    head;
  logic [1:0]       head_op;
  logic [NW-1:0]    head_cycles;

  // A zero length field stands for the full 2^LEN_W cycle span.
  function automatic logic [NW-1:0] expand_len(input logic [LEN_W-1:0] len);
    if (len == '0)
      expand_len = {1'b1, {LEN_W{1'b0}}};
    else
      expand_len = {1'b0, len};
  endfunction

  assign full        = (count == CW'(DEPTH));
  assign empty       = (count == '0);
  assign cmd_ready   = !full;
  assign push        = cmd_valid && !full;
  assign head        = mem[rd_ptr];
  assign head_op     = head[EW-1:LEN_W];
  assign head_cycles = expand_len(head[LEN_W-1:0]);

  // The head is consumed either from IDLE or on the final drive cycle, so
  // consecutive commands run without a bubble.
  assign pop  = !empty && ((state == IDLE) || (cnt == NW'(1)));
  assign busy = (state == DRIVE) || !empty;

  // FIFO storage carries data only; occupancy and pointers gate its validity.
  always_ff @(posedge clk) begin
    if (push && !rst)
      mem[wr_ptr] <= {cmd_op, cmd_len};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      j     <= 1'b0;
      k     <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            state <= DRIVE;
            j     <= head_op[1];
            k     <= head_op[0];
            cnt   <= head_cycles;
            done  <= (head_cycles == NW'(1));
          end else begin
            j    <= 1'b0;
            k    <= 1'b0;
            done <= 1'b0;
          end
        end
        DRIVE: begin
          if (cnt == NW'(1)) begin
            if (pop) begin
              j    <= head_op[1];
              k    <= head_op[0];
              cnt  <= head_cycles;
              done <= (head_cycles == NW'(1));
            end else begin
              state <= IDLE;
              j     <= 1'b0;
              k     <= 1'b0;
              cnt   <= '0;
              done  <= 1'b0;
            end
          end else begin
            cnt  <= cnt - NW'(1);
            done <= (cnt == NW'(2));
          end
        end
        default: begin
          state <= IDLE;
          j     <= 1'b0;
          k     <= 1'b0;
          cnt   <= '0;
          done  <= 1'b0;
        end
      endcase
    end
  end

`ifdef JK_CMD_SEQUENCER_SHADOW_EN
  logic q_reg;

  // Mirrors the downstream flop, which samples the same registered j/k.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_reg <= 1'b0;
    end else begin
      case ({j, k})
        2'b01:   q_reg <= 1'b0;
        2'b10:   q_reg <= 1'b1;
        2'b11:   q_reg <= ~q_reg;
        default: q_reg <= q_reg;
      endcase
    end
  end

  assign q_shadow = q_reg;
`else
  assign q_shadow = 1'b0;
`endif

endmodule
